sub_flag_gen: RTL

- Multi-cycle sequential subtractor. Computes A - B in CHUNK-bit slices, one slice per clock.
- Produces the 32-bit difference plus the negative, carry, overflow and zero flags.
- It is the producer side of the flag interface consumed by the set-less-than result units.
- Carry follows the no-borrow convention: carry = 1 means A >= B unsigned. Consumers form the unsigned less-than as NOT carry.

---
 rtl/sub_flag_gen.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/sub_flag_gen.sv
//------------------------------------------------------------------------------
// sub_flag_gen
//
// Multi-cycle sequential subtractor. Computes a - b as a + ~b + 1, CHUNK bits
// per clock, least significant slice first. Once the last slice is done it
// produces the difference and the negative / carry / overflow / zero flags
// read by the set-less-than result units.
//
// Carry uses the no-borrow convention: carry = 1 means a >= b (unsigned).
// Consumers form the unsigned less-than as ~carry.
//
// Parameters:
//   WIDTH  operand/result width; must be a multiple of CHUNK
//   CHUNK  bits processed per clock (1, 2, 4, 8, 16 or 32)
//          N = WIDTH/CHUNK slice cycles
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-high reset
//   start       request, sampled only while busy = 0 (IDLE or DONE)
//   a, b        minuend / subtrahend, captured on the accepting edge
//   busy        high while slices are being processed (RUN)
//   done        one-cycle pulse; result and flags valid
//   result      a - b modulo 2^WIDTH
//   negative    result MSB
//   carry       carry-out of a + ~b + 1 (1 = no borrow)
//   overflow    signed overflow of a - b
//   zero        result == 0
//
// Optional feature, enabled by defining SUB_FLAG_CMP_EN:
//   lt_unsigned = ~carry
//   lt_signed   = negative ^ overflow
// Both are registered with the flags on the final slice edge.
// When the macro is undefined these ports and their logic are absent.
//------------------------------------------------------------------------------
module sub_flag_gen #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             negative,
  output logic             carry,
  output logic             overflow,
  output logic             zero
`ifdef SUB_FLAG_CMP_EN
  ,
  output logic             lt_unsigned,
  output logic             lt_signed
`endif
);

  localparam int N     = WIDTH / CHUNK;
  // At least one bit, and wide enough to hold N-1.
  localparam int CNT_W = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [WIDTH-1:0] a_reg;      // minuend, shifted right one slice per edge
  logic [WIDTH-1:0] nb_reg;     // inverted subtrahend, shifted the same way
  logic             c_reg;      // carry into the next slice
  logic [CNT_W-1:0] cnt_reg;    // index of the slice being processed
  logic             a_msb_reg;  // captured operand sign bits for overflow
  logic             b_msb_reg;

  logic [WIDTH-1:0] result_reg;
  logic             negative_reg;
  logic             carry_reg;
  logic             overflow_reg;
  logic             zero_reg;

  logic             accept;
  logic             last_slice;
  logic [CHUNK:0]   slice_sum;
  logic [WIDTH-1:0] result_shift;
  logic             neg_next;
  logic             ovf_next;

  // A request is accepted whenever the unit is not processing slices,
  // which includes the DONE cycle (back-to-back operation).
  assign accept     = start && (state_reg != RUN);
  assign last_slice = (cnt_reg == CNT_W'(N - 1));

  //--------------------------------------------------------------------------
  // Slice adder and result shift
  //--------------------------------------------------------------------------
  always_comb begin
    slice_sum = {1'b0, a_reg[CHUNK-1:0]} + {1'b0, nb_reg[CHUNK-1:0]}
              + (CHUNK + 1)'(c_reg);
    // New slice enters at the MSB end; after N shifts the first slice computed
    // has reached bit 0, so the result lands in natural order.
    result_shift = (result_reg >> CHUNK)
                 | (WIDTH'(slice_sum[CHUNK-1:0]) << (WIDTH - CHUNK));
    neg_next = result_shift[WIDTH-1];
    ovf_next = (a_msb_reg != b_msb_reg) && (neg_next != a_msb_reg);
  end

  //--------------------------------------------------------------------------
  // FSM: state register
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  //--------------------------------------------------------------------------
  // FSM: next-state logic
  //--------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_slice) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  //--------------------------------------------------------------------------
  // FSM: outputs
  //--------------------------------------------------------------------------
  always_comb begin
    busy = (state_reg == RUN);
    done = (state_reg == DONE);
  end

  //--------------------------------------------------------------------------
  // Datapath
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_reg      <= '0;
      nb_reg     <= '0;
      c_reg      <= 1'b0;
      cnt_reg    <= '0;
      a_msb_reg  <= 1'b0;
      b_msb_reg  <= 1'b0;
      result_reg <= '0;
    end else if (accept) begin
      a_reg     <= a;
      nb_reg    <= ~b;
      c_reg     <= 1'b1;   // the +1 of the two's complement negation
      cnt_reg   <= '0;
      a_msb_reg <= a[WIDTH-1];
      b_msb_reg <= b[WIDTH-1];
    end else if (state_reg == RUN) begin
      a_reg      <= a_reg >> CHUNK;
      nb_reg     <= nb_reg >> CHUNK;
      c_reg      <= slice_sum[CHUNK];
      cnt_reg    <= cnt_reg + 1'b1;
      result_reg <= result_shift;
    end
  end

  // Flags update only on the edge that completes the last slice, so they stay
  // valid through IDLE and the whole of the next operation's RUN phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      negative_reg <= 1'b0;
      carry_reg    <= 1'b0;
      overflow_reg <= 1'b0;
      zero_reg     <= 1'b0;
    end else if (state_reg == RUN && last_slice) begin
      negative_reg <= neg_next;
      carry_reg    <= slice_sum[CHUNK];
      overflow_reg <= ovf_next;
      zero_reg     <= (result_shift == '0);
    end
  end

  assign result   = result_reg;
  assign negative = negative_reg;
  assign carry    = carry_reg;
  assign overflow = overflow_reg;
  assign zero     = zero_reg;

`ifdef SUB_FLAG_CMP_EN
  logic lt_unsigned_reg;
  logic lt_signed_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lt_unsigned_reg <= 1'b0;
      lt_signed_reg   <= 1'b0;
    end else if (state_reg == RUN && last_slice) begin
      lt_unsigned_reg <= ~slice_sum[CHUNK];
      lt_signed_reg   <= neg_next ^ ovf_next;
    end
  end

  assign lt_unsigned = lt_unsigned_reg;
  assign lt_signed   = lt_signed_reg;
`endif

endmodule
